// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC link blocks.
package cdc_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;

   typedef enum logic {
      IDLE = ST_IDLE,
      HOLD = ST_HOLD
   } state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Assumes STAGES >= 2.
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/dest_domain.sv
// Destination-side receiver of the toggle-handshake CDC link: synchronizes
// the load toggle, captures the source-held word on each toggle edge and
// presents it on a valid/ready interface with a sticky overrun flag.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | holding register empty, dest_valid=0
//   HOLD  | holding register has an unaccepted word, dest_valid=1
module dest_domain
   import cdc_pkg::*;
#(
   parameter int DATAWIDTH   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNTWIDTH    = 16
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic [DATAWIDTH-1:0] src2dest_data,
   input  logic                 src2dest_load,
   input  logic                 dest_ready,
   input  logic                 dest_ovr_clr,
   output logic [DATAWIDTH-1:0] dest_data,
   output logic                 dest_valid,
   output logic                 dest_overrun,
   output logic [CNTWIDTH-1:0]  dest_rx_count
);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
      $error("dest_domain: SYNC_STAGES must be in 2..4");
   end

   // Priming covers the time for the chain to flush whatever level the
   // source left on the toggle while this side was in reset.
   localparam logic [2:0] PRIME_CYC = 3'(SYNC_STAGES + 1);

   logic       sync_q;
   logic       prev_q;
   logic [2:0] prime_cnt;
   logic       primed;
   logic       ev;
   logic       load;
   logic       ovr_set;
   state_t     state_q;
   state_t     state_d;

   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (CLK),
      .rst_n (RSTn),
      .d     (src2dest_load),
      .q     (sync_q)
   );

   assign primed = (prime_cnt == PRIME_CYC);
   assign ev     = (sync_q ^ prev_q) & primed;

   // edge-detect history and post-reset priming counter
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         prev_q    <= 1'b0;
         prime_cnt <= '0;
      end else begin
         prev_q <= sync_q;
         if (!primed) begin
            prime_cnt <= prime_cnt + 3'd1;
         end
      end
   end

   // state register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state, capture permit and overrun detection
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      ovr_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev) begin
               load    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (ev) begin
               if (dest_ready) begin
                  load = 1'b1;
               end else begin
                  ovr_set = 1'b1;
               end
            end else if (dest_ready) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign dest_valid = (state_q == HOLD);

   // holding register, received-word counter and sticky overrun flag
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         dest_data     <= '0;
         dest_rx_count <= '0;
         dest_overrun  <= 1'b0;
      end else begin
         if (load) begin
            dest_data     <= src2dest_data;
            dest_rx_count <= dest_rx_count + CNTWIDTH'(1);
         end
         if (ovr_set) begin
            dest_overrun <= 1'b1;
         end else if (dest_ovr_clr) begin
            dest_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dest_domain.sv
// Testbench for dest_domain: transaction-level reference model checked every
// cycle, table-driven back-to-back vectors, directed corner sequences and a
// randomized phase.
module tb_dest_domain;

   localparam int DW  = 8;
   localparam int SS  = 2;
   localparam int CW  = 4;
   localparam int LAT = SS + 1;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic [DW-1:0] src2dest_data = '0;
   logic          src2dest_load = 1'b0;
   logic          dest_ready = 1'b0;
   logic          dest_ovr_clr = 1'b0;
   logic [DW-1:0] dest_data;
   logic          dest_valid;
   logic          dest_overrun;
   logic [CW-1:0] dest_rx_count;

   dest_domain #(
      .DATAWIDTH   (DW),
      .SYNC_STAGES (SS),
      .CNTWIDTH    (CW)
   ) dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .src2dest_data (src2dest_data),
      .src2dest_load (src2dest_load),
      .dest_ready    (dest_ready),
      .dest_ovr_clr  (dest_ovr_clr),
      .dest_data     (dest_data),
      .dest_valid    (dest_valid),
      .dest_overrun  (dest_overrun),
      .dest_rx_count (dest_rx_count)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference model: a word sent by the source appears LAT edges later;
   // the holding slot either takes it, or flags an overrun if still full.
   bit           m_valid;
   logic [DW-1:0] m_data;
   bit           m_ovr;
   int           m_cnt;
   int           q_due[$];
   logic [DW-1:0] q_dat[$];

   typedef struct {
      logic [DW-1:0] d;
      logic [DW-1:0] exp_d;
      int            exp_cnt;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_ovr   = 0;
      m_cnt   = 0;
      q_due.delete();
      q_dat.delete();
   endtask

   task automatic step();
      bit            arrive;
      bit            set;
      logic [DW-1:0] nd;
      @(posedge CLK);
      cyc++;
      if (!RSTn) begin
         model_reset();
      end else begin
         arrive = 0;
         set    = 0;
         nd     = '0;
         if (q_due.size() > 0 && q_due[0] == cyc) begin
            arrive = 1;
            void'(q_due.pop_front());
            nd = q_dat.pop_front();
         end
         if (m_valid) begin
            if (arrive) begin
               if (dest_ready) begin
                  m_data = nd;
                  m_cnt++;
               end else begin
                  set = 1;
               end
            end else if (dest_ready) begin
               m_valid = 0;
            end
         end else if (arrive) begin
            m_valid = 1;
            m_data  = nd;
            m_cnt++;
         end
         if (set) m_ovr = 1;
         else if (dest_ovr_clr) m_ovr = 0;
      end
      #1;
      chk("model_valid", 32'(dest_valid), 32'(m_valid));
      chk("model_data", 32'(dest_data), 32'(m_data));
      chk("model_overrun", 32'(dest_overrun), 32'(m_ovr));
      chk("model_count", 32'(dest_rx_count), 32'(m_cnt % (1 << CW)));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [DW-1:0] d);
      src2dest_data = d;
      src2dest_load = ~src2dest_load;
      q_due.push_back(cyc + LAT);
      q_dat.push_back(d);
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      #1;
      model_reset();
      chk("async_reset_valid", 32'(dest_valid), 32'd0);
      chk("async_reset_count", 32'(dest_rx_count), 32'd0);
      steps(2);
      RSTn = 1'b1;
      steps(6);
   endtask

   initial begin
      int base;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         tbl[i].d       = DW'(i + 1);
         tbl[i].exp_d   = DW'(i + 1);
         tbl[i].exp_cnt = i + 1;
      end

      // reset state
      #1;
      chk("reset_data", 32'(dest_data), 32'd0);
      chk("reset_valid", 32'(dest_valid), 32'd0);
      chk("reset_overrun", 32'(dest_overrun), 32'd0);
      chk("reset_count", 32'(dest_rx_count), 32'd0);
      steps(2);
      RSTn = 1'b1;
      steps(6);

      // single transfer
      dest_ready = 1'b1;
      send(8'hA5);
      steps(2);
      chk("single_not_early", 32'(dest_valid), 32'd0);
      step();
      chk("single_valid", 32'(dest_valid), 32'd1);
      chk("single_data", 32'(dest_data), 32'hA5);
      chk("single_count", 32'(dest_rx_count), 32'd1);
      step();
      chk("single_drop", 32'(dest_valid), 32'd0);
      steps(3);

      // backpressure
      dest_ready = 1'b0;
      send(8'h3C);
      steps(3);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(dest_valid), 32'd1);
         chk("bp_data", 32'(dest_data), 32'h3C);
         step();
      end
      dest_ready = 1'b1;
      step();
      chk("bp_release", 32'(dest_valid), 32'd0);
      chk("bp_no_ovr", 32'(dest_overrun), 32'd0);
      steps(2);

      // overrun and clear
      base = int'(dest_rx_count);
      dest_ready = 1'b0;
      send(8'h11);
      steps(4);
      send(8'h22);
      steps(4);
      chk("ovr_data", 32'(dest_data), 32'h11);
      chk("ovr_flag", 32'(dest_overrun), 32'd1);
      chk("ovr_count", 32'(dest_rx_count), 32'((base + 1) % (1 << CW)));
      dest_ovr_clr = 1'b1;
      step();
      dest_ovr_clr = 1'b0;
      chk("ovr_clear", 32'(dest_overrun), 32'd0);
      dest_ready = 1'b1;
      steps(2);

      // back-to-back from a fresh reset
      do_reset();
      dest_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].d);
         steps(3);
         chk("b2b_valid", 32'(dest_valid), 32'd1);
         chk("b2b_data", 32'(dest_data), 32'(tbl[i].exp_d));
         chk("b2b_count", 32'(dest_rx_count), 32'(tbl[i].exp_cnt));
         step();
      end
      steps(2);
      chk("b2b_no_ovr", 32'(dest_overrun), 32'd0);

      // reset with toggle high and a word in HOLD
      dest_ready = 1'b0;
      if (src2dest_load) begin
         send(8'h77);
         steps(5);
      end
      send(8'h66);
      steps(5);
      do_reset();
      steps(4);
      chk("rst_hi_no_valid", 32'(dest_valid), 32'd0);
      chk("rst_hi_count", 32'(dest_rx_count), 32'd0);
      chk("rst_hi_load_level", 32'(src2dest_load), 32'd1);
      dest_ready = 1'b1;
      send(8'h5A);
      steps(3);
      chk("rst_hi_valid", 32'(dest_valid), 32'd1);
      chk("rst_hi_data", 32'(dest_data), 32'h5A);
      chk("rst_hi_cnt1", 32'(dest_rx_count), 32'd1);
      steps(2);

      // counter wrap: 17 words with a 4-bit counter
      do_reset();
      dest_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(DW'(8'h80 + i));
         steps(4);
      end
      chk("wrap_count", 32'(dest_rx_count), 32'd1);

      // overrun coinciding with clear: set wins
      dest_ready = 1'b0;
      send(8'hC1);
      steps(4);
      send(8'hC2);
      steps(2);
      dest_ovr_clr = 1'b1;
      step();
      dest_ovr_clr = 1'b0;
      chk("set_wins_flag", 32'(dest_overrun), 32'd1);
      chk("set_wins_data", 32'(dest_data), 32'hC1);
      dest_ovr_clr = 1'b1;
      step();
      dest_ovr_clr = 1'b0;
      chk("late_clear", 32'(dest_overrun), 32'd0);
      dest_ready = 1'b1;
      steps(2);

      // randomized traffic, ready and clear
      for (int n = 0; n < 150; n++) begin
         int gap;
         gap = $urandom_range(4, 7);
         send(DW'($urandom));
         for (int g = 0; g < gap; g++) begin
            dest_ready   = 1'($urandom_range(0, 1));
            dest_ovr_clr = ($urandom_range(0, 7) == 0);
            step();
         end
      end
      dest_ready   = 1'b1;
      dest_ovr_clr = 1'b0;
      steps(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
